fp_result_writeback: RTL
========================

// Module: fp_result_writeback
// PURPOSE
//  Consumer end of the commonAlu result interface (done / save tag / rob tag / 32-bit result).
//  Captures each completed FP result into a small in-order buffer.
//  Arbitrates for the common data bus (CDB) with a req/grant handshake and broadcasts
//  {rob tag, dest tag, value} to the ROB and reservation stations.
//  Back-pressures the issue logic through alu_stall.
// PARAMETERS
//  DEPTH   4   buffer entries; power of 2, >= 2
//  TAG_W   5   ROB / destination tag width
//  DATA_W  32  result width (IEEE-754 single)
// PORTS
//  clk          in   1                 rising-edge clock
//  rst          in   1                 synchronous reset, active-high
//  alu_done     in   1                 one-cycle pulse: result valid this cycle
//  alu_save_tag in   TAG_W             destination (save) tag of the result
//  alu_rob_tag  in   TAG_W             ROB entry tag of the result
//  alu_result   in   DATA_W            result value
//  alu_stall    out  1                 issue logic must not start a new ALU op
//  flush        in   1                 mispredict squash, synchronous
//  cdb_req      out  1                 buffer holds a result to broadcast
//  cdb_grant    in   1                 CDB arbiter grant, same cycle as req
//  cdb_valid    out  1                 broadcast happens this cycle (= cdb_req & cdb_grant)
//  cdb_rob_tag  out  TAG_W             head entry ROB tag
//  cdb_save_tag out  TAG_W             head entry destination tag
//  cdb_data     out  DATA_W            head entry value
//  count        out  $clog2(DEPTH+1)   occupied entries
//  overflow     out  1                 sticky: a result arrived while full and was lost
// BEHAVIOUR
//  Reset: count=0, ptrs=0, overflow=0, cdb_req=0, cdb_valid=0, alu_stall=0.
//   cdb_* data outputs are 0 while empty.
//  Push: on posedge with alu_done=1, write {rob,save,result} at wr_ptr and increment wr_ptr.
//  Pop: on posedge with cdb_req & cdb_grant, increment rd_ptr.
//   Entries drain strictly in arrival order.
//  Pointers wrap modulo DEPTH. count is updated +1 / -1 / unchanged for push only / pop only / both.
//  Head presentation: cdb_req = (count!=0). cdb_* outputs show the head combinationally.
//   Values are stable while req is held without grant.
//  Latency (no bypass): done in cycle N -> cdb_req high in cycle N+1 at the earliest.
//  alu_stall = (count >= DEPTH-1). This covers the one-cycle op already in flight.
//  Full + done, with pop in the same cycle: push accepted and count stays DEPTH.
//  Full + done, without pop: result dropped, overflow set (cleared only by rst), count unchanged.
//  Empty + grant without req: no effect.
//  flush: next cycle count=0 and ptrs=0. A done in the same cycle as flush is discarded.
//   A grant in the same cycle still yields cdb_valid for the current head.
//   overflow is not cleared by flush.
//  rst mid-operation: all entries discarded, no broadcast in the reset cycle (cdb_valid=0).
// CONFIGURATION
//  FP_WB_BYPASS_EN defined: when empty and alu_done=1, cdb_req asserts in the same cycle
//   and cdb_* outputs show the alu_* inputs.
//   - If granted, the result is broadcast and not written (zero latency).
//   - If not granted, it is written as normal.
//   - Bypass is suppressed during flush.
//  FP_WB_BYPASS_EN undefined: no combinational path from alu_* to cdb_*; latency fixed at 1.
// STRUCTURE
//  Package fp_wb_pkg holds:
//   - TAG_W and DATA_W constants;
//   - typedef cdb_entry_t {rob_tag, save_tag, data};
//   - localparam CNT_W.
//  Sub-module wb_fifo: circular buffer of cdb_entry_t with push/pop/flush, count,
//   head-read and full/empty flags. The top level adds the stall threshold, overflow,
//   the bypass mux and the CDB handshake.
// TESTING
//  1 Single result: done with rob=3, save=3, 43061000 and grant held high.
//    -> cdb_valid one cycle later (same cycle with bypass) carrying 3/3/43061000; count returns to 0.
//  2 Back-to-back: two dones (43061000 then c1680000) with grant low, then grant high for 2 cycles.
//    -> broadcast in that order; count goes 2,1,0.
//  3 Fill: 3 dones with grant low -> alu_stall rises once count=3.
//    A 4th done -> count=4. A 5th done without grant -> overflow=1, count=4, head unchanged.
//  4 Full + simultaneous push/pop: count=4, done and grant in the same cycle.
//    -> count stays 4; head advances; the new entry drains last.
//  5 Flush: count=3, flush with done and grant in the same cycle.
//    -> cdb_valid for the old head, then count=0, cdb_req=0, overflow unchanged.
//  6 Reset mid-run: rst asserted with count=2 and grant high.
//    -> cdb_valid=0 in that cycle, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/fp_wb_pkg.sv
// Shared types and widths for the FP result writeback path.
package fp_wb_pkg;
  localparam int TAG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int WB_DEPTH = 4;
  localparam int CNT_W    = $clog2(WB_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  rob_tag;
    logic [TAG_W-1:0]  save_tag;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of CDB entries with push/pop/flush, occupancy count
// and a zeroed head read when empty.
module wb_fifo
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  cdb_entry_t                 wr_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output cdb_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  cdb_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i && !rst) mem[wr_q] <= wr_data_i;
  end

  assign head_o  = empty_o ? '0 : mem[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fp_result_writeback.sv
// FP ALU result writeback: buffers results and broadcasts them on the CDB.
// FP_WB_BYPASS_EN enables a zero-latency path from alu_* to cdb_* when empty.
module fp_result_writeback
  import fp_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_done,
  input  logic [TAG_W-1:0]           alu_save_tag,
  input  logic [TAG_W-1:0]           alu_rob_tag,
  input  logic [DATA_W-1:0]          alu_result,
  output logic                       alu_stall,
  input  logic                       flush,
  output logic                       cdb_req,
  input  logic                       cdb_grant,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_rob_tag,
  output logic [TAG_W-1:0]           cdb_save_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - 1);

  cdb_entry_t in_e, head, out_e;
  logic       push, pop, full, empty;
  logic       overflow_q, overflow_d;

  assign in_e = '{rob_tag: alu_rob_tag, save_tag: alu_save_tag, data: alu_result};

`ifdef FP_WB_BYPASS_EN
  logic byp;
  assign byp     = empty & alu_done & ~flush & ~rst;
  assign out_e   = byp ? in_e : head;
  assign cdb_req = (~empty | byp) & ~rst;
  // A granted bypass result is already broadcast, so it is not stored.
  assign push    = alu_done & ~flush & ~(byp & cdb_grant);
`else
  assign out_e   = head;
  assign cdb_req = ~empty & ~rst;
  assign push    = alu_done & ~flush;
`endif

  assign cdb_valid = cdb_req & cdb_grant;
  assign pop       = cdb_valid & ~empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (in_e),
    .pop_i     (pop),
    .flush_i   (flush),
    .head_o    (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Stall one entry early: the op already in flight still needs a slot.
  assign alu_stall = (count >= STALL_TH);

  always_comb begin
    overflow_d = overflow_q | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow     = overflow_q;
  assign cdb_rob_tag  = out_e.rob_tag;
  assign cdb_save_tag = out_e.save_tag;
  assign cdb_data     = out_e.data;
endmodule
